// File: rtl/herm_tx_ctrl_if.sv
// Signal bundle between the Hermitian-buffer Tx sequencer, the mapper/buffer side and the IFFT stream.
interface herm_tx_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) ();
    logic              map_valid;
    logic              map_ready;
    logic              buf_wren;
    logic              buf_full;
    logic              buf_tx_done;
    logic [ADDR_W-1:0] buf_read_ptr;
    logic [DATA_W-1:0] buf_dout;
    logic [DATA_W-1:0] ifft_tdata;
    logic              ifft_tvalid;
    logic              ifft_tready;
    logic              ifft_tlast;

    modport master (
        input  map_valid, buf_full, buf_dout, ifft_tready,
        output map_ready, buf_wren, buf_tx_done, buf_read_ptr,
               ifft_tdata, ifft_tvalid, ifft_tlast
    );

    modport slave (
        output map_valid, buf_full, buf_dout, ifft_tready,
        input  map_ready, buf_wren, buf_tx_done, buf_read_ptr,
               ifft_tdata, ifft_tvalid, ifft_tlast
    );
endinterface

// File: rtl/herm_tx_ctrl.sv
// Burst sequencer for the OFDM Tx Hermitian buffer: fill from the mapper, wait for expansion,
// stream the expanded symbols to the IFFT through a 2-entry skid FIFO, then clear the buffer.
module herm_tx_ctrl #(
    parameter int ACTIVE_SUBCARR = 28,
    parameter int SYMBOL_NUM     = 8,
    parameter int FFT_POINT      = 64,
    parameter int DATA_W         = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          busy,
    output logic [$clog2(SYMBOL_NUM)-1:0] sym_idx,
    herm_tx_ctrl_if.master                bus
);
    localparam int TOTAL_WR = ACTIVE_SUBCARR * SYMBOL_NUM;
    localparam int TOTAL_RD = FFT_POINT * SYMBOL_NUM;
    localparam int WR_W     = $clog2(TOTAL_WR + 1);
    localparam int RD_W     = $clog2(TOTAL_RD + 1);
    localparam int SMP_W    = $clog2(FFT_POINT);
    localparam int SYM_W    = $clog2(SYMBOL_NUM);

    localparam logic [WR_W-1:0]  WR_LAST  = WR_W'(TOTAL_WR - 1);
    localparam logic [RD_W-1:0]  RD_LAST  = RD_W'(TOTAL_RD - 1);
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(FFT_POINT - 1);
    localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(SYMBOL_NUM - 1);

    typedef enum logic [2:0] {IDLE, FILL, BUILD, STREAM, DRAIN, CLEAR} state_t;
    state_t state_q, state_d;

    logic [WR_W-1:0]   wr_cnt_q;
    logic [RD_W-1:0]   rd_cnt_q;
    logic [RD_W-1:0]   ptr_q;
    logic              vld_p1;
    logic [DATA_W-1:0] fifo_p2 [2];
    logic              fifo_wr_q;
    logic              fifo_rd_q;
    logic [1:0]        occ_q;
    logic [1:0]        slots;
    logic [SMP_W-1:0]  smp_q;
    logic [SYM_W-1:0]  sym_q;
    logic              accept;
    logic              tvalid;
    logic              pop;
    logic              issue;
    logic              last_issue;
    logic              last_beat;

    assign accept = bus.map_valid & bus.map_ready;
    assign tvalid = (occ_q != 2'd0);
    assign pop    = tvalid & bus.ifft_tready;
    // Counting the same-cycle pop lets a read issue every cycle while the sink keeps up,
    // and still guarantees a free FIFO slot for every in-flight word.
    assign slots      = occ_q - {1'b0, pop} + {1'b0, vld_p1};
    assign issue      = (state_q == STREAM) && (slots < 2'd2);
    assign last_issue = issue && (rd_cnt_q == RD_LAST);
    assign last_beat  = pop && (smp_q == SMP_LAST) && (sym_q == SYM_LAST);

    always_comb begin
        state_d         = state_q;
        bus.map_ready   = 1'b0;
        busy            = 1'b1;
        bus.buf_tx_done = rst;
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) state_d = FILL;
            end
            FILL: begin
                bus.map_ready = 1'b1;
                if (bus.map_valid && (wr_cnt_q == WR_LAST)) state_d = BUILD;
            end
            BUILD:   if (bus.buf_full) state_d = STREAM;
            STREAM:  if (last_issue) state_d = DRAIN;
            DRAIN:   if (last_beat) state_d = CLEAR;
            CLEAR: begin
                bus.buf_tx_done = 1'b1;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            ptr_q     <= '0;
            vld_p1    <= 1'b0;
            occ_q     <= 2'd0;
            fifo_wr_q <= 1'b0;
            fifo_rd_q <= 1'b0;
            smp_q     <= '0;
            sym_q     <= '0;
        end else begin
            state_q <= state_d;
            vld_p1  <= issue;
            occ_q   <= occ_q + {1'b0, vld_p1} - {1'b0, pop};
            if (vld_p1) fifo_wr_q <= ~fifo_wr_q;
            if (pop) begin
                fifo_rd_q <= ~fifo_rd_q;
                smp_q     <= (smp_q == SMP_LAST) ? '0 : smp_q + SMP_W'(1);
                if (smp_q == SMP_LAST) sym_q <= sym_q + SYM_W'(1);
            end
            if (accept) wr_cnt_q <= wr_cnt_q + WR_W'(1);
            if (issue) begin
                rd_cnt_q <= rd_cnt_q + RD_W'(1);
                if (!last_issue) ptr_q <= ptr_q + RD_W'(1);
            end
            if (state_q == CLEAR) begin
                wr_cnt_q <= '0;
                rd_cnt_q <= '0;
                ptr_q    <= '0;
                smp_q    <= '0;
                sym_q    <= '0;
            end
        end
    end

    // Stage p1 -> p2: registered buffer word lands in the skid FIFO.
    always_ff @(posedge clk) begin
        if (vld_p1) fifo_p2[fifo_wr_q] <= bus.buf_dout;
    end

    assign bus.buf_wren     = accept;
    assign bus.buf_read_ptr = ptr_q;
    assign bus.ifft_tvalid  = tvalid;
    assign bus.ifft_tdata   = fifo_p2[fifo_rd_q];
    assign bus.ifft_tlast   = tvalid && (smp_q == SMP_LAST);
    assign sym_idx          = sym_q;
endmodule
